// File: rtl/packed_array_monitor.sv
// Receive-side checker for a reset-initialised packed-array bus: verifies the init sample, counts changes, flags zeros.
// Optional concurrent assertions are compiled in when ARRAY_CHK_SVA_EN is defined.
module packed_array_monitor #(
    parameter int unsigned     W          = 4,
    parameter logic [W-1:0]    INIT_VALUE = 4'b1101,
    parameter int unsigned     CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     data_in,
    input  logic             data_valid,
    input  logic             clr,
    output logic [1:0]       state,
    output logic             locked,
    output logic             init_err,
    output logic             zero_err,
    output logic [W-1:0]     last_value,
    output logic [CNT_W-1:0] change_cnt,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    state_t           state_n;
    logic             init_err_n;
    logic             zero_err_n;
    logic [W-1:0]     last_value_n;
    logic [CNT_W-1:0] change_cnt_n;
    logic [CNT_W-1:0] sample_cnt_n;
    logic             accept;

    assign accept = data_valid & ~clr;

    // State and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            locked     <= 1'b0;
            init_err   <= 1'b0;
            zero_err   <= 1'b0;
            last_value <= '0;
            change_cnt <= '0;
            sample_cnt <= '0;
        end else begin
            state_q    <= state_n;
            locked     <= (state_n == TRACK);
            init_err   <= init_err_n;
            zero_err   <= zero_err_n;
            last_value <= last_value_n;
            change_cnt <= change_cnt_n;
            sample_cnt <= sample_cnt_n;
        end
    end

    // Next-state and next-value logic; clr overrides any accepted sample
    always_comb begin
        state_n      = state_q;
        init_err_n   = init_err;
        zero_err_n   = zero_err;
        last_value_n = last_value;
        change_cnt_n = change_cnt;
        sample_cnt_n = sample_cnt;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_value_n = data_in;
                    sample_cnt_n = CNT_ONE;
                    if (data_in == INIT_VALUE) begin
                        state_n = TRACK;
                    end else begin
                        state_n    = FAULT;
                        init_err_n = 1'b1;
                    end
                end
            end
            TRACK: begin
                if (accept) begin
                    last_value_n = data_in;
                    if (sample_cnt != CNT_MAX) begin
                        sample_cnt_n = sample_cnt + CNT_ONE;
                    end
                    if ((data_in != last_value) && (change_cnt != CNT_MAX)) begin
                        change_cnt_n = change_cnt + CNT_ONE;
                    end
                    if (data_in == '0) begin
                        state_n    = FAULT;
                        zero_err_n = 1'b1;
                    end
                end
            end
            FAULT: begin
                state_n = FAULT;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (clr) begin
            state_n      = IDLE;
            init_err_n   = 1'b0;
            zero_err_n   = 1'b0;
            change_cnt_n = '0;
            sample_cnt_n = '0;
        end
    end

    assign state = state_q;

`ifdef ARRAY_CHK_SVA_EN
    a_no_zero: assert property (@(posedge clk) disable iff (reset)
        (state_q == TRACK && data_valid && !clr) |-> data_in != '0);

    a_init: assert property (@(posedge clk) disable iff (reset)
        (state_q == IDLE && data_valid && !clr) |-> data_in == INIT_VALUE);

    a_fault_sticky: assert property (@(posedge clk) disable iff (reset)
        (state_q == FAULT && !clr) |=> state_q == FAULT);

    a_sat: assert property (@(posedge clk) disable iff (reset)
        change_cnt <= sample_cnt);
`else
    // assertions compiled out
`endif

endmodule

// File: tb/tb_packed_array_monitor.sv
// Directed bench for packed_array_monitor: a default instance plus a CNT_W=2 instance for saturation.
module tb_packed_array_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] data_in;
    logic       data_valid;
    logic       clr;

    logic [1:0] a_state;
    logic       a_locked;
    logic       a_init_err;
    logic       a_zero_err;
    logic [3:0] a_last;
    logic [7:0] a_change;
    logic [7:0] a_sample;

    logic [1:0] b_state;
    logic       b_locked;
    logic       b_init_err;
    logic       b_zero_err;
    logic [3:0] b_last;
    logic [1:0] b_change;
    logic [1:0] b_sample;

    int tests;
    int fails;

    packed_array_monitor #(.W(4), .INIT_VALUE(4'b1101), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clr(clr),
        .state(a_state), .locked(a_locked), .init_err(a_init_err), .zero_err(a_zero_err),
        .last_value(a_last), .change_cnt(a_change), .sample_cnt(a_sample)
    );

    packed_array_monitor #(.W(4), .INIT_VALUE(4'b1101), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clr(clr),
        .state(b_state), .locked(b_locked), .init_err(b_init_err), .zero_err(b_zero_err),
        .last_value(b_last), .change_cnt(b_change), .sample_cnt(b_sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, then look just after the edge
    task automatic step(input logic r, input logic v, input logic c, input logic [3:0] d);
        reset      = r;
        data_valid = v;
        clr        = c;
        data_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_state"},    32'(a_state),    32'd0);
        chk({tag, "_locked"},   32'(a_locked),   32'd0);
        chk({tag, "_init_err"}, 32'(a_init_err), 32'd0);
        chk({tag, "_zero_err"}, 32'(a_zero_err), 32'd0);
        chk({tag, "_last"},     32'(a_last),     32'd0);
        chk({tag, "_change"},   32'(a_change),   32'd0);
        chk({tag, "_sample"},   32'(a_sample),   32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1; data_valid = 1'b0; clr = 1'b0; data_in = 4'b0000;
        #1;

        step(1'b1, 1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        chk_a_reset("rst");

        // Good init sample locks
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        chk("init_state",  32'(a_state),    32'd1);
        chk("init_locked", 32'(a_locked),   32'd1);
        chk("init_sample", 32'(a_sample),   32'd1);
        chk("init_last",   32'(a_last),     32'hd);
        chk("init_err0",   32'(a_init_err), 32'd0);
        chk("init_change", 32'(a_change),   32'd0);

        // Change tracking
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        step(1'b0, 1'b1, 1'b0, 4'b0011);
        step(1'b0, 1'b1, 1'b0, 4'b0011);
        step(1'b0, 1'b1, 1'b0, 4'b1000);
        chk("trk_change", 32'(a_change), 32'd2);
        chk("trk_sample", 32'(a_sample), 32'd6);
        chk("trk_last",   32'(a_last),   32'h8);
        chk("trk_state",  32'(a_state),  32'd1);

        // Zero sample faults but is stored and counted
        step(1'b0, 1'b1, 1'b0, 4'b0000);
        chk("zero_state",  32'(a_state),    32'd2);
        chk("zero_err",    32'(a_zero_err), 32'd1);
        chk("zero_sample", 32'(a_sample),   32'd7);
        chk("zero_change", 32'(a_change),   32'd3);
        chk("zero_last",   32'(a_last),     32'h0);
        chk("zero_locked", 32'(a_locked),   32'd0);

        // FAULT ignores valid
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        chk("flt_hold_state",  32'(a_state),  32'd2);
        chk("flt_hold_sample", 32'(a_sample), 32'd7);
        chk("flt_hold_last",   32'(a_last),   32'h0);

        step(1'b0, 1'b0, 1'b1, 4'b0000);
        chk("clr1_state",  32'(a_state),    32'd0);
        chk("clr1_zero",   32'(a_zero_err), 32'd0);
        chk("clr1_sample", 32'(a_sample),   32'd0);
        chk("clr1_change", 32'(a_change),   32'd0);

        // Bad init sample
        step(1'b0, 1'b1, 1'b0, 4'b0110);
        chk("bad_state",  32'(a_state),    32'd2);
        chk("bad_ierr",   32'(a_init_err), 32'd1);
        chk("bad_sample", 32'(a_sample),   32'd1);
        chk("bad_last",   32'(a_last),     32'h6);
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        chk("bad_ign_sample", 32'(a_sample), 32'd1);
        chk("bad_ign_last",   32'(a_last),   32'h6);
        chk("bad_ign_state",  32'(a_state),  32'd2);
        step(1'b0, 1'b0, 1'b1, 4'b0000);
        chk("clr2_state",  32'(a_state),    32'd0);
        chk("clr2_ierr",   32'(a_init_err), 32'd0);
        chk("clr2_sample", 32'(a_sample),   32'd0);
        chk("clr2_last",   32'(a_last),     32'h6);

        // Saturation on the CNT_W=2 instance
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        step(1'b0, 1'b1, 1'b0, 4'b0111);
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        step(1'b0, 1'b1, 1'b0, 4'b0111);
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        step(1'b0, 1'b1, 1'b0, 4'b0111);
        chk("sat_change", 32'(b_change), 32'd3);
        chk("sat_sample", 32'(b_sample), 32'd3);
        chk("sat_state",  32'(b_state),  32'd1);
        chk("sat_locked", 32'(b_locked), 32'd1);
        chk("sat_a_change", 32'(a_change), 32'd5);
        chk("sat_a_sample", 32'(a_sample), 32'd6);

        // clr with valid discards the sample
        step(1'b0, 1'b1, 1'b1, 4'b0000);
        chk("clrv_state",  32'(a_state),    32'd0);
        chk("clrv_sample", 32'(a_sample),   32'd0);
        chk("clrv_last",   32'(a_last),     32'h7);
        chk("clrv_zero",   32'(a_zero_err), 32'd0);

        // Relock, then reset mid-TRACK
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        step(1'b0, 1'b1, 1'b0, 4'b1000);
        chk("relock_state",  32'(a_state),  32'd1);
        chk("relock_change", 32'(a_change), 32'd1);
        chk("relock_sample", 32'(a_sample), 32'd2);
        step(1'b1, 1'b1, 1'b0, 4'b0000);
        chk_a_reset("rst_trk");

        // Reset mid-FAULT, then first accept is the init sample again
        step(1'b0, 1'b1, 1'b0, 4'b0011);
        chk("f2_state", 32'(a_state), 32'd2);
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        chk_a_reset("rst_flt");
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        chk("post_state",  32'(a_state),    32'd1);
        chk("post_ierr",   32'(a_init_err), 32'd0);
        chk("post_sample", 32'(a_sample),   32'd1);

        step(1'b0, 1'b0, 1'b0, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
